// File: rtl/mmio_dbg_pkg.sv
// Shared types and constants for the MMIO debug bridge: FSM state encoding,
// response codes and command field lengths.
package mmio_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        REQ,
        ACCESS,
        RESP
    } state_e;

    localparam logic [7:0] RSP_ACK    = 8'h4B;
    localparam logic [7:0] RSP_ERR    = 8'h3F;
    localparam int         ADDR_BYTES = 3;
    localparam int         DATA_BYTES = 4;

endpackage

// File: rtl/mmio_dbg_bridge_if.sv
// Byte-stream, arbiter and FPRO MMIO signals of the debug bridge. The bridge
// is the bus initiator (master); the slave modport is the environment side.
interface mmio_dbg_bridge_if #(
    parameter int ADDR_W = 21
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              bus_req;
    logic              bus_gnt;
    logic              mmio_cs;
    logic              mmio_wr;
    logic              mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [31:0]       mmio_wr_data;
    logic [31:0]       mmio_rd_data;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_gnt, mmio_rd_data,
        output rx_ready, tx_data, tx_valid, bus_req,
        output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_gnt, mmio_rd_data,
        input  rx_ready, tx_data, tx_valid, bus_req,
        input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data
    );

endinterface

// File: rtl/mmio_dbg_gap_timer.sv
// Inter-byte gap timer: counts enabled idle cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES-1 is reached.
module mmio_dbg_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Saturates at LAST so a stalled owner never sees the count wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/mmio_dbg_bridge.sv
// Host debug initiator for the FPRO MMIO bus: decodes W/R byte commands,
// wins the bus through the arbiter, performs one access and streams the reply.
module mmio_dbg_bridge
    import mmio_dbg_pkg::*;
#(
    parameter int         ADDR_W         = 21,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] CMD_WR         = 8'h57,
    parameter logic [7:0] CMD_RD         = 8'h52
) (
    input  logic              clk,
    input  logic              reset,
    mmio_dbg_bridge_if.master bus,
    output logic              busy,
    output logic              err_timeout
);

    state_e            state, state_next;
    logic [2:0]        cnt;
    logic              is_rd;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [31:0]       resp_q;

    logic rx_ready_q, tx_valid_q, bus_req_q, cs_q, wr_q, rd_q, busy_q, err_q;
    logic rx_fire, tx_fire, is_cmd, gap_expire, abort;

    assign rx_fire = bus.rx_valid && rx_ready_q;
    assign tx_fire = tx_valid_q && bus.tx_ready;
    assign is_cmd  = (bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD);

    // Every accepted byte restarts the gap; the only ways into ADDR/DATA are
    // accepted bytes, so this also covers the clear on state entry.
    mmio_dbg_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk   (clk),
        .reset (reset),
        .clear (rx_fire),
        .enable(state == ADDR || state == DATA),
        .expire(gap_expire)
    );

    // NOTE: every variable gets a default before the case; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        unique case (state)
            IDLE: if (rx_fire) state_next = is_cmd ? ADDR : RESP;
            ADDR: begin
                if (rx_fire) begin
                    if (cnt == 3'(ADDR_BYTES - 1)) state_next = is_rd ? REQ : DATA;
                end else if (gap_expire) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            DATA: begin
                if (rx_fire) begin
                    if (cnt == 3'(DATA_BYTES - 1)) state_next = REQ;
                end else if (gap_expire) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            REQ:     if (bus.bus_gnt) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (tx_fire && cnt == 3'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the ACCESS strobes and
    // tx_valid come straight off flops.
    // NOTE: non-blocking assignments in clocked blocks, so every flop samples
    // the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            bus_req_q  <= 1'b0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_next;
            rx_ready_q <= state_next inside {IDLE, ADDR, DATA};
            tx_valid_q <= state_next == RESP;
            bus_req_q  <= state_next inside {REQ, ACCESS};
            cs_q       <= state_next == ACCESS;
            wr_q       <= state_next == ACCESS && !is_rd;
            rd_q       <= state_next == ACCESS && is_rd;
            busy_q     <= state_next != IDLE;
            err_q      <= abort;
        end
    end

    // cnt is the field byte index while receiving and the bytes still to
    // send while responding; resp_q always presents the next byte at [31:24].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            is_rd  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            resp_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rx_fire) begin
                        is_rd <= bus.rx_data == CMD_RD;
                        cnt   <= '0;
                        if (!is_cmd) begin
                            resp_q <= {RSP_ERR, 24'h0};
                            cnt    <= 3'd1;
                        end
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        // Keeps only the low ADDR_W bits of the 24-bit field.
                        addr_q <= ADDR_W'({addr_q, bus.rx_data});
                        cnt    <= (cnt == 3'(ADDR_BYTES - 1)) ? 3'd0 : cnt + 3'd1;
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        data_q <= {data_q[23:0], bus.rx_data};
                        cnt    <= cnt + 3'd1;
                    end
                end
                ACCESS: begin
                    resp_q <= is_rd ? bus.mmio_rd_data : {RSP_ACK, 24'h0};
                    cnt    <= is_rd ? 3'd4 : 3'd1;
                end
                RESP: begin
                    if (tx_fire) begin
                        resp_q <= {resp_q[23:0], 8'h00};
                        cnt    <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready     = rx_ready_q;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.tx_data      = resp_q[31:24];
    assign bus.bus_req      = bus_req_q;
    assign bus.mmio_cs      = cs_q;
    assign bus.mmio_wr      = wr_q;
    assign bus.mmio_rd      = rd_q;
    assign bus.mmio_addr    = addr_q;
    assign bus.mmio_wr_data = data_q;
    assign busy             = busy_q;
    assign err_timeout      = err_q;

endmodule

// File: tb/tb_mmio_dbg_bridge.sv
// Bench for mmio_dbg_bridge: directed scenarios plus random W/R/bad commands,
// predicted by a command-level model with its own memory image.
module tb_mmio_dbg_bridge;

    localparam int ADDR_W = 21;
    localparam int TO     = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef int iq_t[$];
    typedef struct {
        logic        wr;
        logic        rd;
        addr_t       addr;
        logic [31:0] data;
    } acc_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic busy, err_timeout;

    mmio_dbg_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    mmio_dbg_bridge #(
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TO),
        .CMD_WR        (8'h57),
        .CMD_RD        (8'h52)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int gnt_delay = -1;   // negative: grant tied high
    int tx_mode   = 0;    // 0: ready=1, 1: random, 2: driven by the test

    logic [31:0] sl_mem  [addr_t];
    logic [31:0] ref_mem [addr_t];
    acc_t        acc_q[$];
    logic [7:0]  tx_q[$];
    int          err_cnt    = 0;
    int          req_cycles = 0;
    int          viol       = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input addr_t a);
        return 32'(a) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input addr_t a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic iq_t gaps(input int n, input int mx);
        iq_t g;
        for (int i = 0; i < n; i++) g.push_back(int'($urandom_range(0, mx)));
        return g;
    endfunction

    // MMIO slave: memory image with a per-address default pattern.
    initial begin
        bus.mmio_rd_data = '0;
        forever begin
            @(negedge clk);
            if (reset && bus.mmio_cs && bus.mmio_wr) sl_mem[bus.mmio_addr] = bus.mmio_wr_data;
            bus.mmio_rd_data = sl_mem.exists(bus.mmio_addr) ? sl_mem[bus.mmio_addr]
                                                            : dflt(bus.mmio_addr);
        end
    end

    // Arbiter: grant after gnt_delay cycles of request.
    initial begin
        int w;
        w = 0;
        bus.bus_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gnt_delay < 0) bus.bus_gnt = 1'b1;
            else if (!bus.bus_req) begin
                bus.bus_gnt = 1'b0;
                w = 0;
            end else if (w >= gnt_delay) bus.bus_gnt = 1'b1;
            else w++;
        end
    end

    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tx_mode == 0) bus.tx_ready = 1'b1;
            else if (tx_mode == 1) bus.tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: collects tx bytes and bus accesses, tallies protocol violations.
    initial begin
        logic       granted, prev_cs, tx_pend;
        logic [7:0] tx_hold;
        acc_t       a;
        granted = 1'b0;
        prev_cs = 1'b0;
        tx_pend = 1'b0;
        tx_hold = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                granted = 1'b0;
                prev_cs = 1'b0;
                tx_pend = 1'b0;
            end else begin
                if (tx_pend && (!bus.tx_valid || bus.tx_data !== tx_hold)) begin
                    viol++;
                    $display("protocol violation: tx byte not held while stalled at %0t", $time);
                end
                tx_pend = bus.tx_valid && !bus.tx_ready;
                tx_hold = bus.tx_data;
                if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
                if (err_timeout) err_cnt++;
                if (bus.bus_req) req_cycles++;
                if (bus.mmio_cs) begin
                    if (!granted || !bus.bus_req || prev_cs || bus.mmio_wr == bus.mmio_rd) begin
                        viol++;
                        $display("protocol violation: bad access cycle at %0t", $time);
                    end
                    a.wr   = bus.mmio_wr;
                    a.rd   = bus.mmio_rd;
                    a.addr = bus.mmio_addr;
                    a.data = bus.mmio_wr_data;
                    acc_q.push_back(a);
                    granted = 1'b0;
                end else begin
                    if (bus.mmio_wr || bus.mmio_rd || (prev_cs && bus.bus_req)) begin
                        viol++;
                        $display("protocol violation: strobe/request outside access at %0t", $time);
                    end
                    if (bus.bus_req && bus.bus_gnt) granted = 1'b1;
                end
                prev_cs = bus.mmio_cs;
            end
        end
    end

    // Called at posedge+1 with rx_valid low; returns at posedge+1 after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        if (!ok) check("rx_accept_bound", 0, 1);
    endtask

    task automatic wait_done(input int n_tx, input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (tx_q.size() >= n_tx && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) check({tag, ":done_bound"}, 0, 1);
    endtask

    // Reference: predicts the reply and bus access of one command from the
    // wire protocol alone, keeping its own picture of slave memory.
    task automatic run_cmd(input logic [7:0] cmd[$], input iq_t gp, input string tag);
        logic [7:0]  exp_tx[$];
        acc_t        exp_acc[$];
        acc_t        e;
        logic [23:0] a24;
        logic [31:0] d;
        a24 = {cmd.size() > 3 ? cmd[1] : 8'h0, cmd.size() > 3 ? cmd[2] : 8'h0,
               cmd.size() > 3 ? cmd[3] : 8'h0};
        e.addr = a24[ADDR_W-1:0];
        if (cmd[0] == 8'h57) begin
            d = {cmd[4], cmd[5], cmd[6], cmd[7]};
            e.wr = 1'b1; e.rd = 1'b0; e.data = d;
            exp_acc.push_back(e);
            exp_tx.push_back(8'h4B);
            ref_mem[e.addr] = d;
        end else if (cmd[0] == 8'h52) begin
            d = ref_rd(e.addr);
            e.wr = 1'b0; e.rd = 1'b1; e.data = d;
            exp_acc.push_back(e);
            for (int i = 3; i >= 0; i--) exp_tx.push_back(8'(d >> (8 * i)));
        end else begin
            exp_tx.push_back(8'h3F);
        end
        tx_q.delete();
        acc_q.delete();
        foreach (cmd[i]) send_byte(cmd[i], gp[i]);
        wait_done(exp_tx.size(), tag);
        check({tag, ":tx_count"}, tx_q.size(), exp_tx.size());
        foreach (exp_tx[i])
            if (i < tx_q.size()) check($sformatf("%s:tx%0d", tag, i), tx_q[i], exp_tx[i]);
        check({tag, ":acc_count"}, acc_q.size(), exp_acc.size());
        foreach (exp_acc[i]) begin
            if (i < acc_q.size()) begin
                check({tag, ":acc_wr"}, acc_q[i].wr, exp_acc[i].wr);
                check({tag, ":acc_rd"}, acc_q[i].rd, exp_acc[i].rd);
                check({tag, ":acc_addr"}, acc_q[i].addr, exp_acc[i].addr);
                if (exp_acc[i].wr) check({tag, ":acc_wdata"}, acc_q[i].data, exp_acc[i].data);
            end
        end
        check({tag, ":busy_end"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, got hang expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  cq[$];
        logic [23:0] a24;
        logic [31:0] d;
        logic [7:0]  b;
        addr_t       low;
        int          e0, r0, kind;

        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        #12;
        check("rst_ctrl", {bus.rx_ready, bus.tx_valid, bus.bus_req, bus.mmio_cs,
                           bus.mmio_wr, bus.mmio_rd, busy, err_timeout}, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_addr", bus.mmio_addr, 0);
        check("rst_wdata", bus.mmio_wr_data, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_rx_ready", bus.rx_ready, 1);

        // Write with grant tied high.
        gnt_delay = -1; tx_mode = 0;
        cq = {8'h57, 8'h00, 8'h00, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_cmd(cq, gaps(8, 0), "wr_basic");

        // Read with late grant and a stalling consumer.
        gnt_delay = 5; tx_mode = 1;
        sl_mem[21'h41] = 32'h1234_5678;
        ref_mem[21'h41] = 32'h1234_5678;
        cq = {8'h52, 8'h00, 8'h00, 8'h41};
        run_cmd(cq, gaps(4, 2), "rd_stall");

        cq = {8'h52, 8'hFF, 8'hFF, 8'hFF};
        run_cmd(cq, gaps(4, 1), "rd_trunc");
        if (acc_q.size() > 0) check("trunc_addr", acc_q[0].addr, 21'h1FFFFF);

        cq = {8'h00};
        run_cmd(cq, gaps(1, 0), "bad_cmd");
        cq = {8'h52, 8'h00, 8'h00, 8'h41};
        run_cmd(cq, gaps(4, 1), "rd_after_bad");

        // Gap timeout with the command abandoned after its address MSB.
        gnt_delay = -1; tx_mode = 0;
        tx_q.delete(); acc_q.delete();
        e0 = err_cnt; r0 = req_cycles;
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        repeat (10) @(posedge clk);
        #1;
        check("to_not_early", err_cnt - e0, 0);
        check("to_busy_waiting", busy, 1);
        repeat (20) @(posedge clk);
        #1;
        check("to_pulses", err_cnt - e0, 1);
        check("to_no_req", req_cycles - r0, 0);
        check("to_no_tx", tx_q.size(), 0);
        check("to_no_acc", acc_q.size(), 0);
        check("to_idle", {busy, bus.rx_ready}, 2'b01);

        // A byte landing exactly in the expiry cycle must win.
        e0 = err_cnt;
        cq = {8'h52, 8'h00, 8'h00, 8'h41};
        run_cmd(cq, '{0, 0, TO - 1, 0}, "rd_edge_gap");
        check("edge_gap_no_err", err_cnt - e0, 0);
        cq = {8'h52, 8'h00, 8'h00, 8'h00};
        run_cmd(cq, gaps(4, 0), "rd_after_to");

        // Reset in the middle of a read response.
        tx_mode = 2; bus.tx_ready = 1'b1;
        d = ref_rd(21'h41);
        tx_q.delete();
        send_byte(8'h52, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h41, 0);
        for (int k = 0; k < 100 && tx_q.size() < 2; k++) @(negedge clk);
        check("rst_mid_pre_bytes", tx_q.size(), 2);
        if (tx_q.size() >= 2) check("rst_mid_b0b1", {tx_q[0], tx_q[1]}, {d[31:24], d[23:16]});
        @(posedge clk);
        #1 bus.tx_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_mid_outs", {bus.tx_valid, bus.bus_req, busy}, 0);
        @(negedge clk);
        reset = 1'b1;
        tx_mode = 0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_mid_no_residual", tx_q.size(), 2);
        check("rst_mid_idle", {busy, bus.tx_valid, bus.rx_ready}, 3'b001);

        // Random commands against the reference.
        for (int n = 0; n < 24; n++) begin
            gnt_delay = int'($urandom_range(0, 5)) - 1;
            tx_mode   = int'($urandom_range(0, 1));
            kind      = int'($urandom_range(0, 9));
            case ($urandom_range(0, 3))
                0:       low = 21'h000010;
                1:       low = 21'h0ABCDE;
                2:       low = 21'h1FFFF0;
                default: low = 21'h000041;
            endcase
            a24 = {3'($urandom), low};
            d   = $urandom;
            if (kind < 4)
                cq = {8'h57, a24[23:16], a24[15:8], a24[7:0], d[31:24], d[23:16], d[15:8], d[7:0]};
            else if (kind < 8)
                cq = {8'h52, a24[23:16], a24[15:8], a24[7:0]};
            else begin
                b = 8'($urandom);
                if (b == 8'h57 || b == 8'h52) b = 8'h01;
                cq = {b};
            end
            run_cmd(cq, gaps(cq.size(), 3), $sformatf("rnd%0d", n));
        end

        check("protocol_violations", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
